// File: rtl/fifo_rr_sched_pkg.sv
// Shared constants and FSM state type for the round-robin FIFO read scheduler.
package fifo_sched_pkg;

  localparam int unsigned DEF_NQ    = 4;
  localparam int unsigned DEF_QIDW  = 2;
  localparam int unsigned DEF_BURST = 4;
  localparam int unsigned DEF_BCW   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } sched_state_e;

endpackage

// File: rtl/fifo_rr_sched_if.sv
// Queue-status, read-strobe and output-tag bundle between the scheduler and its environment.
interface fifo_rr_sched_if
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NQ   = DEF_NQ,
  parameter int unsigned QIDW = DEF_QIDW
);
  logic            en;
  logic [NQ-1:0]   qnotempty;
  logic [NQ-1:0]   qrd;
  logic [QIDW-1:0] rdsel;
  logic [NQ-1:0]   gnt;
  logic            out_valid;
  logic [QIDW-1:0] out_qid;
  logic            out_last;
  logic            out_ready;

  modport master (
    input  en, qnotempty, out_ready,
    output qrd, rdsel, gnt, out_valid, out_qid, out_last
  );

  modport slave (
    output en, qnotempty, out_ready,
    input  qrd, rdsel, gnt, out_valid, out_qid, out_last
  );
endinterface

// File: rtl/fifo_rr_sched_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NQ   = 4,
  parameter int unsigned QIDW = 2
) (
  input  logic [NQ-1:0]   req_i,
  input  logic [QIDW-1:0] ptr_i,
  output logic [NQ-1:0]   gnt_o,
  output logic            any_o
);

  // Walk the requests starting at ptr and take the first one found.
  always_comb begin
    int unsigned base;
    int unsigned idx;
    gnt_o = '0;
    any_o = 1'b0;
    base  = (int'(ptr_i) < NQ) ? int'(ptr_i) : 0;
    idx   = 0;
    for (int unsigned k = 0; k < NQ; k++) begin
      idx = base + k;
      if (idx >= NQ) idx = idx - NQ;
      if (!any_o && req_i[idx[QIDW-1:0]]) begin
        gnt_o[idx[QIDW-1:0]] = 1'b1;
        any_o                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_sched.sv
// Round-robin burst read scheduler for NQ queues sharing one synchronous RAM read port.
module fifo_rr_sched
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NQ    = DEF_NQ,
  parameter int unsigned QIDW  = DEF_QIDW,
  parameter int unsigned BURST = DEF_BURST,
  parameter int unsigned BCW   = DEF_BCW
) (
  input logic             clk,
  input logic             rst,
  fifo_rr_sched_if.master bus
);

  sched_state_e    state_q, state_d;
  logic [NQ-1:0]   gnt_q, gnt_d;
  logic [QIDW-1:0] gidx_q, gidx_d;
  logic [QIDW-1:0] ptr_q, ptr_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic            vld_q, vld_d;
  logic [QIDW-1:0] qid_q, qid_d;
  logic            last_q, last_d;

  logic [NQ-1:0]   pick_gnt;
  logic            pick_any;
  logic [QIDW-1:0] pick_idx;
  logic            issue;
  logic            last_issue;

  rr_pick #(
    .NQ   (NQ),
    .QIDW (QIDW)
  ) u_pick (
    .req_i (bus.qnotempty),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .any_o (pick_any)
  );

  // Encode the one-hot pick into the RAM mux select index.
  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NQ; i++) begin
      if (pick_gnt[i]) pick_idx = QIDW'(i);
    end
  end

  // A read may go out only while the output slot is free or being drained this cycle.
  assign issue      = (state_q == ST_SERVE) && bus.qnotempty[gidx_q] && bus.en &&
                      (!vld_q || bus.out_ready);
  assign last_issue = issue && (bcnt_q == BCW'(BURST - 1));

  // Grant FSM, burst counter, rotation pointer and output-tag next state.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    vld_d   = vld_q;
    qid_d   = qid_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.en && pick_any) begin
          state_d = ST_SERVE;
          gnt_d   = pick_gnt;
          gidx_d  = pick_idx;
          bcnt_d  = '0;
        end
      end
      ST_SERVE: begin
        if (issue) bcnt_d = bcnt_q + 1'b1;
        if (last_issue || !bus.qnotempty[gidx_q] || !bus.en) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          // Explicit wrap so non-power-of-two NQ never leaves ptr out of range.
          ptr_d   = (gidx_q == QIDW'(NQ - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      vld_d  = 1'b1;
      qid_d  = gidx_q;
      last_d = last_issue;
    end else if (vld_q && bus.out_ready) begin
      vld_d  = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      vld_q   <= 1'b0;
      qid_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      vld_q   <= vld_d;
      qid_q   <= qid_d;
      last_q  <= last_d;
    end
  end

  assign bus.qrd       = issue ? gnt_q : '0;
  assign bus.gnt       = gnt_q;
  assign bus.rdsel     = gidx_q;
  assign bus.out_valid = vld_q;
  assign bus.out_qid   = qid_q;
  assign bus.out_last  = last_q;

endmodule
